// File: rtl/rr_req_ack_arbiter.sv
// rtl/rr_req_ack_arbiter.sv - round-robin arbiter sharing one req/ack resource
// between N requesters, with per-winner done/err pulses and an ack timeout.
module rr_req_ack_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [N-1:0] done,
  output logic [N-1:0] err,
  output logic         res_req,
  input  logic         res_ack,
  output logic         busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] IDX_LAST = PW'(N - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_q, win_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  done_q, done_d;
  logic [N-1:0]  err_q, err_d;

  logic          sel_found;
  logic [PW-1:0] sel_idx;
  logic [PW-1:0] ptr_next;

  // Search upward from the pointer, wrapping at N; first set bit wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!sel_found && req[(int'(ptr_q) + i) % N]) begin
        sel_found = 1'b1;
        sel_idx   = PW'((int'(ptr_q) + i) % N);
      end
    end
  end

  assign ptr_next = (win_q == IDX_LAST) ? '0 : win_q + PW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = BUSY;
          win_d   = sel_idx;
          gnt_d   = N'(1) << sel_idx;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        // Ack takes precedence over a timeout landing on the same edge.
        if (res_ack) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = ptr_next;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = gnt_q;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = ptr_next;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = (state_q == BUSY);
  assign res_req = (state_q == BUSY);

endmodule

// File: tb/tb_rr_req_ack_arbiter.sv
// tb/tb_rr_req_ack_arbiter.sv - directed vector bench for rr_req_ack_arbiter.
module tb_rr_req_ack_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] done;
  logic [3:0] err;
  logic       res_req;
  logic       res_ack;
  logic       busy;

  int n_cmp;
  int n_bad;

  rr_req_ack_arbiter #(.N(4), .TIMEOUT(15)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .done    (done),
    .err     (err),
    .res_req (res_req),
    .res_ack (res_ack),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic [3:0] gnt;
    logic [3:0] done;
    logic [3:0] err;
    logic       rr;
  } vec_t;

  function automatic logic [13:0] pk(logic [3:0] g, logic [3:0] d, logic [3:0] e, logic r);
    return {g, d, e, r, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] g, input logic [3:0] d,
                         input logic [3:0] e, input logic r);
    chk(name, 32'({gnt, done, err, res_req, busy}), 32'(pk(g, d, e, r)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Interface invariants, sampled on the falling edge.
  logic [3:0] prev_gnt;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt <= '0;
    end else begin
      chk("inv_onehot0_gnt", 32'($onehot0(gnt)), 32'd1);
      chk("inv_rr_eq_busy_eq_gnt", 32'({res_req, busy}), 32'({|gnt, |gnt}));
      chk("inv_done_err_excl", 32'((|done) && (|err)), 32'd0);
      chk("inv_done_err_onehot0", 32'({$onehot0(done), $onehot0(err)}), 32'b11);
      chk("inv_pulse_to_winner", 32'((done | err) & ~prev_gnt), 32'd0);
      prev_gnt <= gnt;
    end
  end

  vec_t vecs[23];

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    req     = '0;
    res_ack = 1'b0;

    // Single requester, pointer skip with wrap, fairness, ack-in-idle, drop while busy.
    vecs[0]  = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1};
    vecs[1]  = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1};
    vecs[2]  = '{4'b0010, 1'b1, 4'b0000, 4'b0010, 4'b0000, 1'b0};
    vecs[3]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[4]  = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1};
    vecs[5]  = '{4'b0001, 1'b1, 4'b0000, 4'b0001, 4'b0000, 1'b0};
    vecs[6]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[7]  = '{4'b1111, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1};
    vecs[8]  = '{4'b1111, 1'b1, 4'b0000, 4'b0010, 4'b0000, 1'b0};
    vecs[9]  = '{4'b1111, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1};
    vecs[10] = '{4'b1111, 1'b1, 4'b0000, 4'b0100, 4'b0000, 1'b0};
    vecs[11] = '{4'b1111, 1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b1};
    vecs[12] = '{4'b1111, 1'b1, 4'b0000, 4'b1000, 4'b0000, 1'b0};
    vecs[13] = '{4'b1111, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1};
    vecs[14] = '{4'b1111, 1'b1, 4'b0000, 4'b0001, 4'b0000, 1'b0};
    vecs[15] = '{4'b1111, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1};
    vecs[16] = '{4'b0000, 1'b1, 4'b0000, 4'b0010, 4'b0000, 1'b0};
    vecs[17] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[18] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[19] = '{4'b0100, 1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b1};
    vecs[20] = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1};
    vecs[21] = '{4'b0100, 1'b1, 4'b0000, 4'b0100, 4'b0000, 1'b0};
    vecs[22] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};

    tick();
    tick();
    chk_out("reset_state", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      req     = vecs[i].req;
      res_ack = vecs[i].ack;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].done, vecs[i].err, vecs[i].rr);
    end

    // Timeout: pointer is 3, so 0100 wins; err lands 15 cycles after the grant cycle.
    req = 4'b0100; res_ack = 1'b0;
    tick();
    chk_out("to_grant", 4'b0100, 4'b0000, 4'b0000, 1'b1);
    for (int k = 1; k < 15; k++) begin
      tick();
      chk_out($sformatf("to_wait%0d", k), 4'b0100, 4'b0000, 4'b0000, 1'b1);
    end
    tick();
    chk_out("to_err", 4'b0000, 4'b0000, 4'b0100, 1'b0);
    req = 4'b0000;
    tick();
    chk_out("to_after", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Ack on the very edge the counter would hit TIMEOUT.
    req = 4'b1000;
    tick();
    chk_out("ato_grant", 4'b1000, 4'b0000, 4'b0000, 1'b1);
    for (int k = 1; k < 15; k++) begin
      tick();
      chk_out($sformatf("ato_wait%0d", k), 4'b1000, 4'b0000, 4'b0000, 1'b1);
    end
    res_ack = 1'b1;
    tick();
    chk_out("ato_done", 4'b0000, 4'b1000, 4'b0000, 1'b0);
    req = 4'b0000; res_ack = 1'b0;
    tick();
    chk_out("ato_after", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Move pointer to 2, then reset mid-BUSY with 1000 granted.
    req = 4'b0010;
    tick();
    chk_out("pre_grant1", 4'b0010, 4'b0000, 4'b0000, 1'b1);
    res_ack = 1'b1;
    tick();
    chk_out("pre_done1", 4'b0000, 4'b0010, 4'b0000, 1'b0);
    req = 4'b1000; res_ack = 1'b0;
    tick();
    chk_out("rst_busy", 4'b1000, 4'b0000, 4'b0000, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_async_drop", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick();
    req = 4'b0000;
    #1;
    rst_n = 1'b1;
    res_ack = 1'b1;
    tick();
    chk_out("rst_stray_ack", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    req = 4'b1010; res_ack = 1'b0;
    tick();
    chk_out("rst_ptr0_grant", 4'b0010, 4'b0000, 4'b0000, 1'b1);
    res_ack = 1'b1;
    tick();
    chk_out("rst_ptr0_done", 4'b0000, 4'b0010, 4'b0000, 1'b0);
    req = 4'b1000; res_ack = 1'b0;
    tick();
    chk_out("rst_regrant3", 4'b1000, 4'b0000, 4'b0000, 1'b1);
    res_ack = 1'b1;
    tick();
    chk_out("rst_regrant3_done", 4'b0000, 4'b1000, 4'b0000, 1'b0);
    req = 4'b0000; res_ack = 1'b0;
    tick();
    chk_out("final_idle", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
